// File: rtl/frb_det_pkg.sv
// Shared types and helpers for the FRB threshold detector and its timestamp stage.
package frb_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DIN_WIDTH_DEF  = 25;
  localparam int DIN_POINT_DEF  = 24;
  localparam int TS_WIDTH_DEF   = 32;
  localparam int WCNT_WIDTH_DEF = 16;

  // Increment v, sticking at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] lim;
    if (w >= 32) begin
      lim = 32'hFFFF_FFFF;
    end else begin
      lim = (32'd1 << w) - 32'd1;
    end
    if (v >= lim) begin
      return lim;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/frb_ts_counter.sv
// Valid-gated sample timestamp counter; wraps silently at 2^TS_WIDTH.
module frb_ts_counter #(
  parameter int TS_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  output logic [TS_WIDTH-1:0] count
);

  logic [TS_WIDTH-1:0] count_r;

  // Count qualified samples; the value seen by a sample is its own index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= count_r + TS_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/frb_threshold_detector.sv
// Detrended-power threshold detector: forms din - avg, tracks above-threshold
// events and reports start timestamp, peak excess and width, then applies dead time.
module frb_threshold_detector
  import frb_det_pkg::*;
#(
  parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
  parameter int DIN_POINT  = DIN_POINT_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int WCNT_WIDTH = WCNT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DIN_WIDTH-1:0]  din,
  input  logic signed [DIN_WIDTH-1:0]  avg,
  input  logic                         din_valid,
  input  logic                         en,
  input  logic signed [DIN_WIDTH:0]    thresh,
  input  logic [WCNT_WIDTH-1:0]        holdoff_len,
  output logic                         det_valid,
  output logic [TS_WIDTH-1:0]          det_ts,
  output logic signed [DIN_WIDTH:0]    det_peak,
  output logic [WCNT_WIDTH-1:0]        det_width,
  output logic                         busy
);

  localparam int DW = DIN_WIDTH + 1;

  // The binary point only labels the fixed-point format; it must lie inside the word.
  if (DIN_POINT >= DIN_WIDTH) begin : g_point_chk
    $error("frb_threshold_detector: DIN_POINT must be below DIN_WIDTH");
  end

  logic [TS_WIDTH-1:0]   ts_s;
  logic                  v1_r;
  logic signed [DW-1:0]  diff1_r;
  logic [TS_WIDTH-1:0]   idx1_r;
  logic                  above_s;

  state_t                state_r, state_s;
  logic [TS_WIDTH-1:0]   ev_ts_r, ev_ts_s;
  logic signed [DW-1:0]  ev_peak_r, ev_peak_s;
  logic [WCNT_WIDTH-1:0] ev_width_r, ev_width_s;
  logic [WCNT_WIDTH-1:0] hcnt_r, hcnt_s;
  logic                  det_valid_r, det_valid_s;
  logic [TS_WIDTH-1:0]   det_ts_r, det_ts_s;
  logic signed [DW-1:0]  det_peak_r, det_peak_s;
  logic [WCNT_WIDTH-1:0] det_width_r, det_width_s;
  logic                  busy_r;

  frb_ts_counter #(.TS_WIDTH(TS_WIDTH)) u_ts (
    .clk   (clk),
    .rst_n (rst),
    .inc   (din_valid),
    .count (ts_s)
  );

  // Stage 1: exact detrended excess, tagged with its sample index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r    <= 1'b0;
      diff1_r <= '0;
      idx1_r  <= '0;
    end else begin
      v1_r <= din_valid;
      if (din_valid) begin
        diff1_r <= {din[DIN_WIDTH-1], din} - {avg[DIN_WIDTH-1], avg};
        idx1_r  <= ts_s;
      end else begin
        diff1_r <= diff1_r;
        idx1_r  <= idx1_r;
      end
    end
  end

  assign above_s = (diff1_r > thresh);

  // Stage 2: event FSM, advancing only on qualified samples.
  always_comb begin
    state_s     = state_r;
    ev_ts_s     = ev_ts_r;
    ev_peak_s   = ev_peak_r;
    ev_width_s  = ev_width_r;
    hcnt_s      = hcnt_r;
    det_valid_s = 1'b0;
    det_ts_s    = det_ts_r;
    det_peak_s  = det_peak_r;
    det_width_s = det_width_r;
    if (v1_r) begin
      case (state_r)
        IDLE: begin
          if (en && above_s) begin
            state_s    = TRIG;
            ev_ts_s    = idx1_r;
            ev_peak_s  = diff1_r;
            ev_width_s = WCNT_WIDTH'(1);
          end else begin
            state_s = IDLE;
          end
        end
        TRIG: begin
          if (en && above_s) begin
            if (diff1_r > ev_peak_r) begin
              ev_peak_s = diff1_r;
            end else begin
              ev_peak_s = ev_peak_r;
            end
            ev_width_s = WCNT_WIDTH'(sat_inc(32'(ev_width_r), WCNT_WIDTH));
          end else begin
            det_valid_s = 1'b1;
            det_ts_s    = ev_ts_r;
            det_peak_s  = ev_peak_r;
            det_width_s = ev_width_r;
            if (holdoff_len == '0) begin
              state_s = IDLE;
            end else begin
              state_s = HOLD;
              hcnt_s  = holdoff_len;
            end
          end
        end
        HOLD: begin
          // A zero count here is unreachable; treat it as expired rather than wrap.
          if (hcnt_r <= WCNT_WIDTH'(1)) begin
            state_s = IDLE;
            hcnt_s  = '0;
          end else begin
            state_s = HOLD;
            hcnt_s  = hcnt_r - WCNT_WIDTH'(1);
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state, event accumulators and report registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      ev_ts_r     <= '0;
      ev_peak_r   <= '0;
      ev_width_r  <= '0;
      hcnt_r      <= '0;
      det_valid_r <= 1'b0;
      det_ts_r    <= '0;
      det_peak_r  <= '0;
      det_width_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ev_ts_r     <= ev_ts_s;
      ev_peak_r   <= ev_peak_s;
      ev_width_r  <= ev_width_s;
      hcnt_r      <= hcnt_s;
      det_valid_r <= det_valid_s;
      det_ts_r    <= det_ts_s;
      det_peak_r  <= det_peak_s;
      det_width_r <= det_width_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  assign det_valid = det_valid_r;
  assign det_ts    = det_ts_r;
  assign det_peak  = det_peak_r;
  assign det_width = det_width_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_frb_threshold_detector.sv
// Directed self-checking bench for frb_threshold_detector.
module tb_frb_threshold_detector;

  localparam logic signed [24:0] BASE = 25'sh0100000;

  logic               clk;
  logic               rst;
  logic signed [24:0] din;
  logic signed [24:0] avg;
  logic               din_valid;
  logic               en;
  logic signed [25:0] thresh;
  logic [15:0]        holdoff_len;
  logic               det_valid;
  logic [31:0]        det_ts;
  logic signed [25:0] det_peak;
  logic [15:0]        det_width;
  logic               busy;
  logic               w_det_valid;
  logic [3:0]         w_det_ts;
  logic signed [25:0] w_det_peak;
  logic [15:0]        w_det_width;
  logic               w_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ev_cnt = 0;
  int ev_cyc = 0;
  int w_ev_cnt = 0;

  frb_threshold_detector dut (
    .clk(clk), .rst(rst), .din(din), .avg(avg), .din_valid(din_valid), .en(en),
    .thresh(thresh), .holdoff_len(holdoff_len), .det_valid(det_valid), .det_ts(det_ts),
    .det_peak(det_peak), .det_width(det_width), .busy(busy)
  );

  frb_threshold_detector #(.TS_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .din(din), .avg(avg), .din_valid(din_valid), .en(en),
    .thresh(thresh), .holdoff_len(holdoff_len), .det_valid(w_det_valid), .det_ts(w_det_ts),
    .det_peak(w_det_peak), .det_width(w_det_width), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (det_valid === 1'b1) begin
      ev_cnt = ev_cnt + 1;
      ev_cyc = cyc;
    end
    if (w_det_valid === 1'b1) w_ev_cnt = w_ev_cnt + 1;
  end

  task automatic push(input int e, input logic v);
    @(negedge clk);
    din       = BASE + 25'(e);
    avg       = BASE;
    din_valid = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(0, 1'b0);
    #1;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset();
    #1;
    total++; if (det_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", det_valid); end
    total++; if (det_ts !== 32'd0) begin bad++; $display("FAIL reset_ts: got %0d want 0", det_ts); end
    total++; if (det_peak !== 26'd0) begin bad++; $display("FAIL reset_peak: got %0h want 0", det_peak); end
    total++; if (det_width !== 16'd0) begin bad++; $display("FAIL reset_width: got %0d want 0", det_width); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (dut.ts_s !== 32'd0) begin bad++; $display("FAIL reset_tscnt: got %0d want 0", dut.ts_s); end
  endtask

  task automatic test_quiet;
    int e0;
    apply_reset();
    e0 = ev_cnt;
    for (int i = 0; i < 1000; i++) push(0, 1'b1);
    idle(3);
    total++; if (ev_cnt != e0) begin bad++; $display("FAIL quiet_events: got %0d want 0", ev_cnt - e0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL quiet_busy: got %0b want 0", busy); end
    total++; if (dut.ts_s !== 32'd1000) begin bad++; $display("FAIL quiet_tscnt: got %0d want 1000", dut.ts_s); end
  endtask

  // Excess 0x800 on 50..54 with 0xC00 at 52; optionally a non-valid cycle after each sample.
  task automatic test_burst(input string nm, input bit gaps);
    int e0;
    int endc;
    int e;
    apply_reset();
    e0 = ev_cnt;
    endc = 0;
    for (int i = 0; i < 60; i++) begin
      e = (i >= 50 && i <= 54) ? ((i == 52) ? 'hC00 : 'h800) : 0;
      push(e, 1'b1);
      if (i == 55) endc = cyc;
      if (gaps) push(0, 1'b0);
    end
    idle(4);
    total++; if (ev_cnt - e0 != 1) begin bad++; $display("FAIL %s_count: got %0d want 1", nm, ev_cnt - e0); end
    total++; if (ev_cyc - endc != 2) begin bad++; $display("FAIL %s_latency: got %0d want 2", nm, ev_cyc - endc); end
    total++; if (det_ts !== 32'd50) begin bad++; $display("FAIL %s_ts: got %0d want 50", nm, det_ts); end
    total++; if (det_peak !== 26'h0000C00) begin bad++; $display("FAIL %s_peak: got %0h want c00", nm, det_peak); end
    total++; if (det_width !== 16'd5) begin bad++; $display("FAIL %s_width: got %0d want 5", nm, det_width); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy: got %0b want 0", nm, busy); end
  endtask

  task automatic test_holdoff;
    int e0;
    int e;
    apply_reset();
    holdoff_len = 16'd10;
    e0 = ev_cnt;
    for (int i = 0; i < 80; i++) begin
      e = ((i >= 50 && i <= 54) || i == 60 || i == 61 || i == 70) ? 'h800 : 0;
      push(e, 1'b1);
      #1;
      if (i == 63) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL holdoff_busy: got %0b want 1", busy); end
      end
      if (i == 72) begin
        total++; if (ev_cnt - e0 != 1) begin bad++; $display("FAIL holdoff_ignored: got %0d want 1", ev_cnt - e0); end
      end
    end
    idle(4);
    total++; if (ev_cnt - e0 != 2) begin bad++; $display("FAIL holdoff_count: got %0d want 2", ev_cnt - e0); end
    total++; if (det_ts !== 32'd70) begin bad++; $display("FAIL holdoff_ts: got %0d want 70", det_ts); end
    total++; if (det_width !== 16'd1) begin bad++; $display("FAIL holdoff_width: got %0d want 1", det_width); end
    total++; if (det_peak !== 26'h0000800) begin bad++; $display("FAIL holdoff_peak: got %0h want 800", det_peak); end
    holdoff_len = 16'd0;
  endtask

  task automatic test_equal_thresh;
    int e0;
    apply_reset();
    e0 = ev_cnt;
    for (int i = 0; i < 10; i++) push('h400, 1'b1);
    idle(3);
    total++; if (ev_cnt != e0) begin bad++; $display("FAIL eq_events: got %0d want 0", ev_cnt - e0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL eq_busy: got %0b want 0", busy); end
    push('h401, 1'b1);
    idle(2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL above_busy: got %0b want 1", busy); end
    push(0, 1'b1);
    idle(3);
    total++; if (det_ts !== 32'd10) begin bad++; $display("FAIL above_ts: got %0d want 10", det_ts); end
    total++; if (det_width !== 16'd1) begin bad++; $display("FAIL above_width: got %0d want 1", det_width); end
  endtask

  task automatic test_neg_thresh;
    int e0;
    apply_reset();
    thresh = '1;
    e0 = ev_cnt;
    for (int i = 0; i < 3; i++) push(0, 1'b1);
    idle(3);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL neg_busy: got %0b want 1", busy); end
    total++; if (ev_cnt != e0) begin bad++; $display("FAIL neg_early: got %0d want 0", ev_cnt - e0); end
    thresh = 26'sh0000400;
    push(0, 1'b1);
    idle(3);
    total++; if (ev_cnt - e0 != 1) begin bad++; $display("FAIL neg_count: got %0d want 1", ev_cnt - e0); end
    total++; if (det_width !== 16'd3) begin bad++; $display("FAIL neg_width: got %0d want 3", det_width); end
    total++; if (det_peak !== 26'd0) begin bad++; $display("FAIL neg_peak: got %0h want 0", det_peak); end
  endtask

  task automatic test_en_drop;
    int e0;
    apply_reset();
    e0 = ev_cnt;
    for (int i = 0; i < 3; i++) push('h800, 1'b1);
    idle(2);
    en = 1'b0;
    for (int i = 0; i < 4; i++) push('h800, 1'b1);
    idle(3);
    total++; if (ev_cnt - e0 != 1) begin bad++; $display("FAIL en_count: got %0d want 1", ev_cnt - e0); end
    total++; if (det_width !== 16'd3) begin bad++; $display("FAIL en_width: got %0d want 3", det_width); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_busy: got %0b want 0", busy); end
    en = 1'b1;
  endtask

  task automatic test_saturate;
    int e0;
    apply_reset();
    e0 = ev_cnt;
    for (int i = 0; i < 70000; i++) push('h800, 1'b1);
    push(0, 1'b1);
    idle(3);
    total++; if (ev_cnt - e0 != 1) begin bad++; $display("FAIL sat_count: got %0d want 1", ev_cnt - e0); end
    total++; if (det_width !== 16'hFFFF) begin bad++; $display("FAIL sat_width: got %0h want ffff", det_width); end
    total++; if (det_ts !== 32'd0) begin bad++; $display("FAIL sat_ts: got %0d want 0", det_ts); end
  endtask

  // The 4-bit-timestamp instance wraps after 16 samples.
  task automatic test_wrap;
    int w0;
    apply_reset();
    w0 = w_ev_cnt;
    for (int i = 0; i < 16; i++) push(0, 1'b1);
    push('h800, 1'b1);
    push('h800, 1'b1);
    push(0, 1'b1);
    idle(3);
    total++; if (w_ev_cnt - w0 != 1) begin bad++; $display("FAIL wrap_count: got %0d want 1", w_ev_cnt - w0); end
    total++; if (w_det_ts !== 4'd0) begin bad++; $display("FAIL wrap_ts: got %0d want 0", w_det_ts); end
    total++; if (w_det_width !== 16'd2) begin bad++; $display("FAIL wrap_width: got %0d want 2", w_det_width); end
    total++; if (det_ts !== 32'd16) begin bad++; $display("FAIL nowrap_ts: got %0d want 16", det_ts); end
  endtask

  task automatic test_reset_mid;
    int e0;
    int e;
    apply_reset();
    e0 = ev_cnt;
    for (int i = 0; i <= 52; i++) begin
      e = (i == 10 || i == 11 || i >= 50) ? 'h800 : 0;
      push(e, 1'b1);
    end
    push(0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    total++; if (det_ts !== 32'd0) begin bad++; $display("FAIL rmid_ts: got %0d want 0", det_ts); end
    total++; if (det_width !== 16'd0) begin bad++; $display("FAIL rmid_width: got %0d want 0", det_width); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (ev_cnt - e0 != 1) begin bad++; $display("FAIL rmid_noreport: got %0d want 1", ev_cnt - e0); end
    total++; if (dut.ts_s !== 32'd0) begin bad++; $display("FAIL rmid_tscnt: got %0d want 0", dut.ts_s); end
    for (int i = 0; i < 10; i++) push((i == 5 || i == 6) ? 'h800 : 0, 1'b1);
    idle(3);
    total++; if (ev_cnt - e0 != 2) begin bad++; $display("FAIL rmid_count: got %0d want 2", ev_cnt - e0); end
    total++; if (det_ts !== 32'd5) begin bad++; $display("FAIL rmid_next_ts: got %0d want 5", det_ts); end
    total++; if (det_width !== 16'd2) begin bad++; $display("FAIL rmid_next_width: got %0d want 2", det_width); end
  endtask

  initial begin
    rst         = 1'b0;
    din         = BASE;
    avg         = BASE;
    din_valid   = 1'b0;
    en          = 1'b1;
    thresh      = 26'sh0000400;
    holdoff_len = 16'd0;
    test_reset();
    test_quiet();
    test_burst("burst", 1'b0);
    test_burst("gaps", 1'b1);
    test_holdoff();
    test_equal_thresh();
    test_neg_thresh();
    test_en_drop();
    test_wrap();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
